// File: rtl/sid_chip_filter.sv
// Chamberlin state-variable filter in the style of the SID multimode filter.
// One iteration per clock; dry/LP/HP/BP responses are mixed onto a registered output.
module sid_chip_filter #(
   parameter int AUDIO_BDEPTH       = 8,
   parameter int FILTER_BDEPTH      = 16,
   parameter int FILTER_COEF_BDEPTH = 16,
   parameter int INPUT_GAIN_BITS    = 6
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic        [FILTER_COEF_BDEPTH-1:0] f_coefficient,
   input  logic        [FILTER_COEF_BDEPTH-1:0] q_coefficient,
   input  logic                                 en_pass,
   input  logic                                 en_lowpass,
   input  logic                                 en_highpass,
   input  logic                                 en_bandpass,
   input  logic signed [AUDIO_BDEPTH-1:0]       audio_in,
   output logic signed [AUDIO_BDEPTH-1:0]       audio_out
);

   localparam int W      = FILTER_BDEPTH;
   localparam int CW     = FILTER_COEF_BDEPTH;
   localparam int AW     = AUDIO_BDEPTH;
   localparam int G      = INPUT_GAIN_BITS;
   localparam int PW     = W + CW + 1;
   localparam int SW     = PW + 2;
   localparam int MW     = W + 2;
   localparam int F_FRAC = CW;
   localparam int Q_FRAC = CW - 4;

   localparam logic signed [SW-1:0] S_MAX = $signed({{(SW-W+1){1'b0}}, {(W-1){1'b1}}});
   localparam logic signed [SW-1:0] S_MIN = $signed({{(SW-W+1){1'b1}}, {(W-1){1'b0}}});
   localparam logic signed [MW-1:0] A_MAX = $signed({{(MW-AW+1){1'b0}}, {(AW-1){1'b1}}});
   localparam logic signed [MW-1:0] A_MIN = $signed({{(MW-AW+1){1'b1}}, {(AW-1){1'b0}}});

   function automatic logic signed [PW-1:0] ext_wp(input logic signed [W-1:0] v);
      return $signed({{(PW-W){v[W-1]}}, v});
   endfunction

   function automatic logic signed [SW-1:0] ext_ws(input logic signed [W-1:0] v);
      return $signed({{(SW-W){v[W-1]}}, v});
   endfunction

   function automatic logic signed [SW-1:0] ext_ps(input logic signed [PW-1:0] v);
      return $signed({{(SW-PW){v[PW-1]}}, v});
   endfunction

   function automatic logic signed [MW-1:0] ext_wm(input logic signed [W-1:0] v);
      return $signed({{(MW-W){v[W-1]}}, v});
   endfunction

   function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] v);
      if (v > S_MAX)
         return $signed({1'b0, {(W-1){1'b1}}});
      else if (v < S_MIN)
         return $signed({1'b1, {(W-1){1'b0}}});
      else
         return v[W-1:0];
   endfunction

   function automatic logic signed [AW-1:0] clamp_a(input logic signed [MW-1:0] v);
      if (v > A_MAX)
         return $signed({1'b0, {(AW-1){1'b1}}});
      else if (v < A_MIN)
         return $signed({1'b1, {(AW-1){1'b0}}});
      else
         return v[AW-1:0];
   endfunction

   logic signed [W-1:0]  lp_reg, lp_next;
   logic signed [W-1:0]  bp_reg, bp_next;
   logic signed [AW-1:0] audio_out_reg, audio_out_next;
   logic signed [W-1:0]  x_val, hp_val;
   logic signed [PW-1:0] f_ext, q_ext;
   logic signed [PW-1:0] f_bp_prod, q_bp_prod, f_hp_prod;
   logic signed [SW-1:0] lp_sum, hp_sum, bp_sum;
   logic signed [MW-1:0] mix_sum, mix_scaled;
   logic signed [W-1:0]  mix_src  [4];
   logic signed [MW-1:0] mix_term [4];
   logic        [3:0]    mix_en;

   // Input is lifted into the filter's fixed-point domain so small signals keep precision.
   assign x_val = $signed({{(W-AW){audio_in[AW-1]}}, audio_in}) <<< G;
   assign f_ext = $signed({{(PW-CW){1'b0}}, f_coefficient});
   assign q_ext = $signed({{(PW-CW){1'b0}}, q_coefficient});

   // lp uses the old bp; hp uses the new lp; bp uses the new hp.
   always_comb begin
      f_bp_prod = f_ext * ext_wp(bp_reg);
      q_bp_prod = q_ext * ext_wp(bp_reg);
      lp_sum    = ext_ws(lp_reg) + ext_ps(f_bp_prod >>> F_FRAC);
      lp_next   = sat_w(lp_sum);
      hp_sum    = ext_ws(x_val) - ext_ws(lp_next) - ext_ps(q_bp_prod >>> Q_FRAC);
      hp_val    = sat_w(hp_sum);
      f_hp_prod = f_ext * ext_wp(hp_val);
      bp_sum    = ext_ws(bp_reg) + ext_ps(f_hp_prod >>> F_FRAC);
      bp_next   = sat_w(bp_sum);
   end

   assign mix_en     = {en_bandpass, en_highpass, en_lowpass, en_pass};
   assign mix_src[0] = x_val;
   assign mix_src[1] = lp_next;
   assign mix_src[2] = hp_val;
   assign mix_src[3] = bp_next;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_mix
         assign mix_term[gi] = mix_en[gi] ? ext_wm(mix_src[gi]) : '0;
      end
   endgenerate

   // Four W-bit terms always fit in W+2 bits, so the mix itself never wraps.
   always_comb begin
      mix_sum        = mix_term[0] + mix_term[1] + mix_term[2] + mix_term[3];
      mix_scaled     = mix_sum >>> G;
      audio_out_next = clamp_a(mix_scaled);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lp_reg        <= '0;
         bp_reg        <= '0;
         audio_out_reg <= '0;
      end else begin
         lp_reg        <= lp_next;
         bp_reg        <= bp_next;
         audio_out_reg <= audio_out_next;
      end
   end

   assign audio_out = audio_out_reg;

endmodule

// File: tb/tb_sid_chip_filter.sv
// Directed bench for sid_chip_filter: hand-computed filter iterations and
// saturation/settling scenarios, one task per feature.
module tb_sid_chip_filter;

   logic              clk = 1'b0;
   logic              rst;
   logic       [15:0] f_coefficient;
   logic       [15:0] q_coefficient;
   logic              en_pass, en_lowpass, en_highpass, en_bandpass;
   logic signed [7:0] audio_in;
   logic signed [7:0] audio_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sid_chip_filter #(
      .AUDIO_BDEPTH       (8),
      .FILTER_BDEPTH      (16),
      .FILTER_COEF_BDEPTH (16),
      .INPUT_GAIN_BITS    (6)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .f_coefficient (f_coefficient),
      .q_coefficient (q_coefficient),
      .en_pass       (en_pass),
      .en_lowpass    (en_lowpass),
      .en_highpass   (en_highpass),
      .en_bandpass   (en_bandpass),
      .audio_in      (audio_in),
      .audio_out     (audio_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_en(input logic p, input logic l, input logic h, input logic b);
      en_pass     = p;
      en_lowpass  = l;
      en_highpass = h;
      en_bandpass = b;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic signed [7:0] exp_v;
      rst = 1'b1;
      audio_in = 8'sd100;
      f_coefficient = 16'd4096;
      q_coefficient = 16'd4096;
      set_en(1, 1, 1, 1);
      exp_v = 8'sd0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (audio_out !== exp_v) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %0d expected %0d", i, audio_out, exp_v);
         end
      end
      $display("reset_hold in=100 out=%0d", audio_out);
      // Release with high-pass only: first iteration from zero state gives hp = x.
      set_en(0, 0, 1, 0);
      rst = 1'b0;
      step();
      exp_v = 8'sd100;
      checks++;
      if (audio_out !== exp_v) begin
         errors++;
         $display("FAIL reset_release: got %0d expected %0d", audio_out, exp_v);
      end
      $display("reset_release in=100 out=%0d", audio_out);
   endtask

   task automatic test_pass_through();
      int vec [3] = '{100, -128, 127};
      logic signed [7:0] exp_v;
      logic signed [7:0] prev_v;
      set_en(1, 0, 0, 0);
      apply_reset();
      prev_v = 8'sd0;
      for (int i = 0; i < 3; i++) begin
         audio_in = 8'(vec[i]);
         #1;
         checks++;
         if (audio_out !== prev_v) begin
            errors++;
            $display("FAIL pass_latency %0d: got %0d expected %0d", i, audio_out, prev_v);
         end
         step();
         exp_v = 8'(vec[i]);
         checks++;
         if (audio_out !== exp_v) begin
            errors++;
            $display("FAIL pass_through %0d: got %0d expected %0d", i, audio_out, exp_v);
         end
         $display("pass_through in=%0d out=%0d", vec[i], audio_out);
         prev_v = exp_v;
      end
   endtask

   task automatic test_zero_cutoff_highpass();
      int vec [2] = '{100, -50};
      logic signed [7:0] exp_v;
      f_coefficient = 16'd0;
      q_coefficient = 16'd4096;
      set_en(0, 0, 1, 0);
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         audio_in = 8'(vec[i]);
         step();
         exp_v = 8'(vec[i]);
         checks++;
         if (audio_out !== exp_v) begin
            errors++;
            $display("FAIL f0_highpass %0d: got %0d expected %0d", i, audio_out, exp_v);
         end
         $display("f0_highpass in=%0d out=%0d", vec[i], audio_out);
      end
   endtask

   task automatic test_dc_lowpass();
      f_coefficient = 16'd4096;
      q_coefficient = 16'd4096;
      set_en(0, 1, 0, 0);
      audio_in = 8'sd50;
      apply_reset();
      for (int i = 0; i < 500; i++) step();
      checks++;
      if (int'(audio_out) < 49 || int'(audio_out) > 51) begin
         errors++;
         $display("FAIL dc_lowpass_settle: got %0d expected 50+-1", audio_out);
      end
      $display("dc_lowpass in=50 out=%0d", audio_out);
   endtask

   // Runs straight after the DC low-pass, so lp/bp hold a large state when reset hits.
   task automatic test_midreset_highpass();
      int exp_hp [3] = '{50, 46, 43};
      logic signed [7:0] exp_v;
      rst = 1'b1;
      step();
      exp_v = 8'sd0;
      checks++;
      if (audio_out !== exp_v) begin
         errors++;
         $display("FAIL midreset: got %0d expected %0d", audio_out, exp_v);
      end
      rst = 1'b0;
      set_en(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         exp_v = 8'(exp_hp[i]);
         checks++;
         if (audio_out !== exp_v) begin
            errors++;
            $display("FAIL dc_highpass_iter %0d: got %0d expected %0d", i, audio_out, exp_v);
         end
         $display("dc_highpass in=50 out=%0d", audio_out);
      end
      for (int i = 0; i < 497; i++) step();
      checks++;
      if (int'(audio_out) < -1 || int'(audio_out) > 1) begin
         errors++;
         $display("FAIL dc_highpass_decay: got %0d expected 0+-1", audio_out);
      end
      $display("dc_highpass_decay out=%0d", audio_out);
   endtask

   task automatic test_saturation();
      int vec [2] = '{127, -128};
      int bad;
      logic signed [7:0] exp_v;
      f_coefficient = 16'd4096;
      q_coefficient = 16'd4096;
      set_en(1, 1, 0, 0);
      for (int s = 0; s < 2; s++) begin
         audio_in = 8'(vec[s]);
         apply_reset();
         exp_v = 8'(vec[s]);
         bad = 0;
         for (int i = 0; i < 300; i++) begin
            step();
            if (audio_out !== exp_v) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL sat_hold %0d: got %0d expected %0d (%0d bad cycles)",
                     vec[s], audio_out, exp_v, bad);
         end
         $display("sat_hold in=%0d out=%0d", vec[s], audio_out);
      end
   endtask

   // Extreme f/q drive hp far past full scale; only saturation (not wrap) yields these.
   task automatic test_internal_saturation();
      int exp_hp [3] = '{127, -128, 127};
      logic signed [7:0] exp_v;
      f_coefficient = 16'd65535;
      q_coefficient = 16'd65535;
      set_en(0, 0, 1, 0);
      audio_in = 8'sd127;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         exp_v = 8'(exp_hp[i]);
         checks++;
         if (audio_out !== exp_v) begin
            errors++;
            $display("FAIL internal_sat %0d: got %0d expected %0d", i, audio_out, exp_v);
         end
         $display("internal_sat in=127 out=%0d", audio_out);
      end
   endtask

   task automatic test_no_enables();
      logic signed [7:0] exp_v;
      set_en(0, 0, 0, 0);
      audio_in = 8'sd100;
      step();
      exp_v = 8'sd0;
      checks++;
      if (audio_out !== exp_v) begin
         errors++;
         $display("FAIL no_enables: got %0d expected %0d", audio_out, exp_v);
      end
      $display("no_enables in=100 out=%0d", audio_out);
   endtask

   task automatic test_zero_cutoff_bandpass();
      int bad = 0;
      f_coefficient = 16'd0;
      q_coefficient = 16'd4096;
      set_en(0, 0, 0, 1);
      apply_reset();
      for (int h = 0; h < 4; h++) begin
         audio_in = (h % 2 == 0) ? 8'sd127 : 8'h80;
         for (int i = 0; i < 16; i++) begin
            step();
            if (audio_out !== 8'sd0) bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL f0_bandpass: got %0d expected 0 (%0d bad cycles)", audio_out, bad);
      end
      $display("f0_bandpass square out=%0d", audio_out);
   endtask

   task automatic test_square_lowpass();
      int prev;
      int delta;
      int max_step = 0;
      int end_val [4];
      f_coefficient = 16'd100;
      q_coefficient = 16'd4096;
      set_en(0, 1, 0, 0);
      audio_in = 8'sd0;
      apply_reset();
      prev = 0;
      for (int h = 0; h < 4; h++) begin
         audio_in = (h % 2 == 0) ? 8'sd127 : 8'h80;
         for (int i = 0; i < 32 * 101; i++) begin
            step();
            delta = int'(audio_out) - prev;
            if (delta < 0) delta = -delta;
            if (delta > max_step) max_step = delta;
            prev = int'(audio_out);
         end
         end_val[h] = int'(audio_out);
         $display("square_lowpass half %0d out=%0d", h, audio_out);
      end
      checks++;
      if (max_step > 2) begin
         errors++;
         $display("FAIL square_step: got max step %0d expected <= 2", max_step);
      end
      for (int h = 0; h < 4; h++) begin
         checks++;
         if ((h % 2 == 0 && end_val[h] < 64) || (h % 2 == 1 && end_val[h] > -64)) begin
            errors++;
            $display("FAIL square_level half %0d: got %0d expected %s", h, end_val[h],
                     (h % 2 == 0) ? ">= 64" : "<= -64");
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      f_coefficient = '0;
      q_coefficient = '0;
      set_en(0, 0, 0, 0);
      audio_in = '0;
      test_reset();
      test_pass_through();
      test_zero_cutoff_highpass();
      test_dc_lowpass();
      test_midreset_highpass();
      test_saturation();
      test_internal_saturation();
      test_no_enables();
      test_zero_cutoff_bandpass();
      test_square_lowpass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
